// File: rtl/p2b_byte_pkg.sv
// Shared widths, FSM encoding and lane-mapping helpers for the byte lane packer.
// The offset helper defines where stream byte k lands on the 64-bit lane bus.
package p2b_byte_pkg;

   localparam int BYTE_W = 8;
   localparam int BUS_W  = 64;
   localparam int CNT_W  = 4;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } acc_state_t;

   function automatic int calc_bpw(input int lanes, input int gear);
      return (lanes * gear) / BYTE_W;
   endfunction

   // Each lane owns a 16-bit field; successive passes over the lanes fill the upper byte.
   function automatic int slot_offset(input int k, input int lanes);
      return 16 * (k % lanes) + BYTE_W * (k / lanes);
   endfunction

   function automatic bit lanes_legal(input int lanes);
      return (lanes == 1) || (lanes == 2) || (lanes == 4);
   endfunction

   function automatic bit gear_legal(input int gear);
      return (gear == 8) || (gear == 16);
   endfunction

endpackage

// File: rtl/byte_out_reg.sv
// One-entry output register: loads a word when empty or draining, holds it
// stable while the consumer stalls.
module byte_out_reg
   import p2b_byte_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [BUS_W-1:0] load_data,
   input  logic             load_last,
   input  logic [CNT_W-1:0] load_cnt,
   output logic             word_valid,
   input  logic             word_ready,
   output logic [BUS_W-1:0] word_data,
   output logic             word_last,
   output logic [CNT_W-1:0] word_cnt
);

   // Valid/ready: a word moves when valid && ready on the same clock edge; a
   // presented word and its data stay unchanged until that edge.
   assign load_ready = !word_valid || word_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_valid <= 1'b0;
         word_data  <= '0;
         word_last  <= 1'b0;
         word_cnt   <= '0;
      end else if (load_valid && load_ready) begin
         word_valid <= 1'b1;
         word_data  <= load_data;
         word_last  <= load_last;
         word_cnt   <= load_cnt;
      end else if (word_ready) begin
         word_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/byte_lane_packer.sv
// Packs a valid/ready byte stream into lane-interleaved 64-bit words for a
// byte-lane TX bus, padding short words at packet end.
module byte_lane_packer
   import p2b_byte_pkg::*;
#(
   parameter int          NUM_TX_LANE = 4,
   parameter int          TX_GEAR     = 16,
   parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
   input  logic        byte_clk,
   input  logic        rst_n,
   input  logic        s_byte_valid,
   input  logic [7:0]  s_byte_data,
   input  logic        s_byte_last,
   output logic        s_byte_ready,
   input  logic        byte_ready,
   output logic        byte_en,
   output logic [63:0] byte_dout,
   output logic        byte_last,
   output logic [3:0]  byte_cnt,
   output logic [31:0] byte_total
);

   localparam int               BPW      = calc_bpw(NUM_TX_LANE, TX_GEAR);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BPW - 1);

   generate
      if (!lanes_legal(NUM_TX_LANE) || !gear_legal(TX_GEAR)) begin : g_bad_param
         $error("byte_lane_packer: NUM_TX_LANE must be 1/2/4 and TX_GEAR 8/16");
      end
   endgenerate

   // Empty staging word: pad in every used slot, zero on unused lanes/bytes.
   function automatic logic [BUS_W-1:0] pad_word();
      logic [BUS_W-1:0] w;
      w = '0;
      for (int k = 0; k < BPW; k++) begin
         w[slot_offset(k, NUM_TX_LANE) +: BYTE_W] = PAD_BYTE;
      end
      return w;
   endfunction

   localparam logic [BUS_W-1:0] PAD_WORD = pad_word();

   acc_state_t       state;
   acc_state_t       state_nx;
   logic [CNT_W-1:0] idx;
   logic [BUS_W-1:0] stage;
   logic             stage_last;
   logic [CNT_W-1:0] stage_cnt;
   logic             take;
   logic             closing;
   logic             load_ready;

   assign s_byte_ready = (state == ST_FILL);
   assign take         = s_byte_valid && s_byte_ready;
   assign closing      = take && ((idx == LAST_IDX) || s_byte_last);

   always_comb begin
      state_nx = state;
      case (state)
         ST_FILL: if (closing)    state_nx = ST_FULL;
         ST_FULL: if (load_ready) state_nx = ST_FILL;
         default:                 state_nx = ST_FILL;
      endcase
   end

   always_ff @(posedge byte_clk or negedge rst_n) begin
      if (!rst_n) state <= ST_FILL;
      else        state <= state_nx;
   end

   always_ff @(posedge byte_clk or negedge rst_n) begin
      if (!rst_n) begin
         idx        <= '0;
         stage      <= PAD_WORD;
         stage_last <= 1'b0;
         stage_cnt  <= '0;
      end else if (take) begin
         for (int k = 0; k < BPW; k++) begin
            if (idx == CNT_W'(k)) stage[slot_offset(k, NUM_TX_LANE) +: BYTE_W] <= s_byte_data;
         end
         if (closing) begin
            idx        <= '0;
            stage_last <= s_byte_last;
            stage_cnt  <= idx + 1'b1;
         end else begin
            idx <= idx + 1'b1;
         end
      end else if ((state == ST_FULL) && load_ready) begin
         // Word handed off: refill the staging word with pad for the next packet.
         stage      <= PAD_WORD;
         stage_last <= 1'b0;
      end
   end

   byte_out_reg u_out_reg (
      .clk        (byte_clk),
      .rst_n      (rst_n),
      .load_valid (state == ST_FULL),
      .load_ready (load_ready),
      .load_data  (stage),
      .load_last  (stage_last),
      .load_cnt   (stage_cnt),
      .word_valid (byte_en),
      .word_ready (byte_ready),
      .word_data  (byte_dout),
      .word_last  (byte_last),
      .word_cnt   (byte_cnt)
   );

   always_ff @(posedge byte_clk or negedge rst_n) begin
      if (!rst_n)                     byte_total <= '0;
      else if (byte_en && byte_ready) byte_total <= byte_total + 32'(byte_cnt);
   end

endmodule

// File: tb/tb_byte_lane_packer.sv
// Bench for byte_lane_packer: four configurations driven one at a time and
// scored against a packet-level reference model.
module tb_byte_lane_packer;

   logic byte_clk = 1'b0;
   logic rst_n;
   always #5 byte_clk = ~byte_clk;

   logic        s_valid [4];
   logic [7:0]  s_data  [4];
   logic        s_last  [4];
   logic        s_ready [4];
   logic        dready  [4];
   logic        en      [4];
   logic [63:0] dout    [4];
   logic        blast   [4];
   logic [3:0]  cnt     [4];
   logic [31:0] total   [4];

   byte_lane_packer #(.NUM_TX_LANE(4), .TX_GEAR(16), .PAD_BYTE(8'h00)) u_dut0 (
      .byte_clk(byte_clk), .rst_n(rst_n), .s_byte_valid(s_valid[0]), .s_byte_data(s_data[0]),
      .s_byte_last(s_last[0]), .s_byte_ready(s_ready[0]), .byte_ready(dready[0]), .byte_en(en[0]),
      .byte_dout(dout[0]), .byte_last(blast[0]), .byte_cnt(cnt[0]), .byte_total(total[0]));
   byte_lane_packer #(.NUM_TX_LANE(2), .TX_GEAR(8), .PAD_BYTE(8'h00)) u_dut1 (
      .byte_clk(byte_clk), .rst_n(rst_n), .s_byte_valid(s_valid[1]), .s_byte_data(s_data[1]),
      .s_byte_last(s_last[1]), .s_byte_ready(s_ready[1]), .byte_ready(dready[1]), .byte_en(en[1]),
      .byte_dout(dout[1]), .byte_last(blast[1]), .byte_cnt(cnt[1]), .byte_total(total[1]));
   byte_lane_packer #(.NUM_TX_LANE(1), .TX_GEAR(16), .PAD_BYTE(8'hA5)) u_dut2 (
      .byte_clk(byte_clk), .rst_n(rst_n), .s_byte_valid(s_valid[2]), .s_byte_data(s_data[2]),
      .s_byte_last(s_last[2]), .s_byte_ready(s_ready[2]), .byte_ready(dready[2]), .byte_en(en[2]),
      .byte_dout(dout[2]), .byte_last(blast[2]), .byte_cnt(cnt[2]), .byte_total(total[2]));
   byte_lane_packer #(.NUM_TX_LANE(4), .TX_GEAR(8), .PAD_BYTE(8'h00)) u_dut3 (
      .byte_clk(byte_clk), .rst_n(rst_n), .s_byte_valid(s_valid[3]), .s_byte_data(s_data[3]),
      .s_byte_last(s_last[3]), .s_byte_ready(s_ready[3]), .byte_ready(dready[3]), .byte_en(en[3]),
      .byte_dout(dout[3]), .byte_last(blast[3]), .byte_cnt(cnt[3]), .byte_total(total[3]));

   function automatic int lanes_of(input int d);
      case (d)
         0: return 4;
         1: return 2;
         2: return 1;
         default: return 4;
      endcase
   endfunction

   function automatic int bpw_of(input int d);
      case (d)
         0: return 8;
         1: return 2;
         2: return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [7:0] pad_of(input int d);
      return (d == 2) ? 8'hA5 : 8'h00;
   endfunction

   logic [7:0]  in_data [$];
   bit          in_last [$];
   logic [68:0] exp_q   [$];
   logic [7:0]  acc_q   [$];
   logic [63:0] out_log [$];
   logic [31:0] tot_model [4];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          en_cycles;
   int          last_hs;
   bit          interval_chk = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: collect a packet's bytes, cut into BPW groups, place byte k of a
   // group at lane k%L, byte slot k/L of that lane's 16-bit field.
   task automatic model_accept(input int d, input logic [7:0] b, input bit l);
      logic [63:0] w;
      int          pos;
      acc_q.push_back(b);
      if (l || acc_q.size() == bpw_of(d)) begin
         w = '0;
         for (int k = 0; k < bpw_of(d); k++) begin
            pos = 16 * (k % lanes_of(d)) + 8 * (k / lanes_of(d));
            w[pos +: 8] = (k < acc_q.size()) ? acc_q[k] : pad_of(d);
         end
         exp_q.push_back({l, 4'(acc_q.size()), w});
         acc_q.delete();
      end
   endtask

   task automatic run(input int d, input int vpct, input int rpct, input int stall, input int ready_chk_cyc);
      int          cyc = 0;
      int          pos = 0;
      bit          pend = 1'b0;
      bit          prev_stall = 1'b0;
      logic [63:0] prev_dout = '0;
      logic [68:0] e;
      en_cycles = 0;
      last_hs   = -1;
      out_log.delete();
      while ((pos < in_data.size() || exp_q.size() > 0 || en[d]) && cyc < 5000) begin
         @(negedge byte_clk);
         if (!pend && pos < in_data.size() && $urandom_range(99) < vpct) pend = 1'b1;
         s_valid[d] = pend;
         s_data[d]  = pend ? in_data[pos] : 8'($urandom);
         s_last[d]  = pend ? in_last[pos] : 1'b0;
         dready[d]  = (cyc >= stall) && ($urandom_range(99) < rpct);
         #1;
         check("byte_total", 64'(total[d]), 64'(tot_model[d]));
         if (prev_stall) begin
            check("hold_en", 64'(en[d]), 64'd1);
            check("hold_dout", dout[d], prev_dout);
         end
         if (cyc == ready_chk_cyc) check("s_ready_full", 64'(s_ready[d]), 64'd0);
         if (en[d]) en_cycles++;
         if (d == 3 && en[d]) check("unused_bytes", dout[d] & 64'hFF00_FF00_FF00_FF00, 64'd0);
         if (en[d] && dready[d]) begin
            if (exp_q.size() == 0) begin
               check("extra_word", 64'd1, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("dout", dout[d], e[63:0]);
               check("cnt", 64'(cnt[d]), 64'(e[67:64]));
               check("last", 64'(blast[d]), 64'(e[68]));
            end
            out_log.push_back(dout[d]);
            tot_model[d] += 32'(cnt[d]);
            if (interval_chk && last_hs >= 0) check("interval", 64'(cyc - last_hs), 64'd5);
            last_hs = cyc;
         end
         if (pend && s_ready[d]) begin
            model_accept(d, in_data[pos], in_last[pos]);
            pos++;
            pend = 1'b0;
         end
         prev_stall = en[d] && !dready[d];
         prev_dout  = dout[d];
         cyc++;
         @(posedge byte_clk);
      end
      if (cyc >= 5000) check("timeout", 64'd1, 64'd0);
      @(negedge byte_clk);
      s_valid[d] = 1'b0;
      s_last[d]  = 1'b0;
      dready[d]  = 1'b1;
      #1;
      check("byte_total_end", 64'(total[d]), 64'(tot_model[d]));
      in_data.delete();
      in_last.delete();
   endtask

   task automatic push_byte(input logic [7:0] b, input bit l);
      in_data.push_back(b);
      in_last.push_back(l);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         s_valid[i] = 1'b0; s_data[i] = '0; s_last[i] = 1'b0; dready[i] = 1'b1; tot_model[i] = '0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge byte_clk);
      @(negedge byte_clk);
      check("rst_ready", 64'(s_ready[0]), 64'd1);
      check("rst_en", 64'(en[0]), 64'd0);
      check("rst_dout", dout[0], 64'd0);
      check("rst_cnt", 64'(cnt[0]), 64'd0);
      rst_n = 1'b1;

      // 4 lanes, gear 16: one full packet of 00..07
      for (int i = 0; i < 8; i++) push_byte(8'(i), i == 7);
      run(0, 100, 100, 0, -1);
      check("t1_en_cycles", 64'(en_cycles), 64'd1);
      check("t1_words", 64'(out_log.size()), 64'd1);
      if (out_log.size() >= 1) check("t1_word", out_log[0], 64'h07_03_06_02_05_01_04_00);
      check("t1_total", 64'(total[0]), 64'd8);

      // 2 lanes, gear 8: AA BB CC
      push_byte(8'hAA, 1'b0); push_byte(8'hBB, 1'b0); push_byte(8'hCC, 1'b1);
      run(1, 100, 100, 0, -1);
      check("t2_words", 64'(out_log.size()), 64'd2);
      if (out_log.size() >= 2) begin
         check("t2_word0", out_log[0], 64'h0000_0000_00BB_00AA);
         check("t2_word1", out_log[1], 64'h0000_0000_0000_00CC);
      end
      check("t2_total", 64'(total[1]), 64'd3);

      // 1 lane, gear 16, downstream stalled for 5 cycles
      for (int i = 0; i < 10; i++) push_byte(8'($urandom), (i == 4) || (i == 9));
      run(2, 100, 100, 5, 5);
      check("t3_words", 64'(out_log.size()), 64'd6);

      // 4 lanes, gear 8, continuous 400 bytes
      interval_chk = 1'b1;
      for (int i = 0; i < 400; i++) push_byte(8'($urandom), i == 399);
      run(3, 100, 100, 0, -1);
      interval_chk = 1'b0;
      check("t4_words", 64'(out_log.size()), 64'd100);

      // Reset mid-word, then a fresh 1-byte packet must land in slot 0
      for (int i = 0; i < 3; i++) push_byte(8'($urandom), 1'b0);
      run(0, 100, 100, 0, -1);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_ready", 64'(s_ready[0]), 64'd1);
      check("mid_rst_en", 64'(en[0]), 64'd0);
      check("mid_rst_dout", dout[0], 64'd0);
      check("mid_rst_last", 64'(blast[0]), 64'd0);
      check("mid_rst_cnt", 64'(cnt[0]), 64'd0);
      check("mid_rst_total", 64'(total[0]), 64'd0);
      acc_q.delete();
      exp_q.delete();
      for (int i = 0; i < 4; i++) tot_model[i] = '0;
      @(negedge byte_clk);
      rst_n = 1'b1;
      push_byte(8'h5A, 1'b1);
      run(0, 100, 100, 0, -1);
      if (out_log.size() >= 1) check("post_rst_word", out_log[0], 64'h0000_0000_0000_005A);
      else check("post_rst_words", 64'(out_log.size()), 64'd1);

      // byte_total wrap
      @(negedge byte_clk);
      force u_dut0.byte_total = 32'hFFFF_FFFE;
      #1 release u_dut0.byte_total;
      tot_model[0] = 32'hFFFF_FFFE;
      for (int i = 0; i < 8; i++) push_byte(8'($urandom), i == 7);
      run(0, 100, 100, 0, -1);
      check("wrap_total", 64'(total[0]), 64'h0000_0006);

      // Random traffic on every configuration
      for (int d = 0; d < 4; d++) begin
         for (int i = 0; i < 200; i++) push_byte(8'($urandom), ($urandom_range(99) < 12) || (i == 199));
         run(d, 70, 60, 0, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
